// File: rtl/axi_mem_burst_sched_pkg.sv
// Shared types and helpers for the AXI memory burst scheduler: FSM states,
// burst/response encodings and per-beat address arithmetic.
package axi_mem_sched_pkg;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StRead      = 2'd1,
    StWrite     = 2'd2,
    StWriteResp = 2'd3
  } state_e;

  typedef logic [1:0]  burst_t;
  typedef logic [1:0]  resp_t;
  typedef logic [63:0] addr_t;

  localparam burst_t BurstFixed = 2'd0;
  localparam burst_t BurstIncr  = 2'd1;
  localparam burst_t BurstWrap  = 2'd2;
  localparam burst_t BurstRsvd  = 2'd3;

  localparam resp_t RespOkay   = 2'd0;
  localparam resp_t RespSlverr = 2'd2;

  function automatic logic wrap_len_ok(logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  function automatic logic burst_err(burst_t burst, logic [7:0] len,
                                     logic [2:0] size, logic [2:0] max_size);
    return (burst == BurstRsvd) || (size > max_size) ||
           ((burst == BurstWrap) && !wrap_len_ok(len));
  endfunction

  // Malformed bursts still run their full length, walking as INCR.
  function automatic burst_t eff_burst(burst_t burst, logic [7:0] len);
    return ((burst == BurstRsvd) || ((burst == BurstWrap) && !wrap_len_ok(len)))
           ? BurstIncr : burst;
  endfunction

  function automatic addr_t next_beat_addr(addr_t addr, logic [7:0] len,
                                           logic [2:0] size, burst_t burst);
    addr_t step;
    addr_t mask;
    addr_t nxt;
    step = 64'd1 << size;
    mask = ((addr_t'(len) + 64'd1) << size) - 64'd1;
    nxt  = addr + step;
    case (burst)
      BurstFixed: return addr;
      BurstWrap:  return (addr & ~mask) | (nxt & mask);
      default:    return nxt;
    endcase
  endfunction

endpackage

// File: rtl/axi_mem_burst_sched_if.sv
// AX/W/B handshake and memory beat-request bundle of the burst scheduler.
// The slave modport is the scheduler's view; master is the environment's.
interface axi_mem_burst_sched_if
  import axi_mem_sched_pkg::*;
#(
  parameter int AddrWidth = 64,
  parameter int IdWidth   = 6
);
  logic                 aw_valid_i;
  logic                 aw_ready_o;
  logic [AddrWidth-1:0] aw_addr_i;
  logic [7:0]           aw_len_i;
  logic [2:0]           aw_size_i;
  burst_t               aw_burst_i;
  logic [IdWidth-1:0]   aw_id_i;

  logic                 ar_valid_i;
  logic                 ar_ready_o;
  logic [AddrWidth-1:0] ar_addr_i;
  logic [7:0]           ar_len_i;
  logic [2:0]           ar_size_i;
  burst_t               ar_burst_i;
  logic [IdWidth-1:0]   ar_id_i;

  logic                 w_valid_i;
  logic                 w_ready_o;
  logic                 w_last_i;

  logic                 mem_req_o;
  logic                 mem_gnt_i;
  logic                 mem_we_o;
  logic [AddrWidth-1:0] mem_addr_o;
  logic [IdWidth-1:0]   mem_id_o;
  logic                 mem_last_o;
  logic                 mem_err_o;

  logic                 b_valid_o;
  logic                 b_ready_i;
  logic [IdWidth-1:0]   b_id_o;
  resp_t                b_resp_o;

  modport slave (
    input  aw_valid_i, aw_addr_i, aw_len_i, aw_size_i, aw_burst_i, aw_id_i,
    input  ar_valid_i, ar_addr_i, ar_len_i, ar_size_i, ar_burst_i, ar_id_i,
    input  w_valid_i, w_last_i, mem_gnt_i, b_ready_i,
    output aw_ready_o, ar_ready_o, w_ready_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_id_o, mem_last_o, mem_err_o,
    output b_valid_o, b_id_o, b_resp_o
  );

  modport master (
    output aw_valid_i, aw_addr_i, aw_len_i, aw_size_i, aw_burst_i, aw_id_i,
    output ar_valid_i, ar_addr_i, ar_len_i, ar_size_i, ar_burst_i, ar_id_i,
    output w_valid_i, w_last_i, mem_gnt_i, b_ready_i,
    input  aw_ready_o, ar_ready_o, w_ready_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_id_o, mem_last_o, mem_err_o,
    input  b_valid_o, b_id_o, b_resp_o
  );

endinterface

// File: rtl/axi_mem_burst_sched_addr_gen.sv
// Beat address and beat counter for the active burst; loads the start
// address on acceptance and steps once per granted beat.
module axi_burst_addr_gen
  import axi_mem_sched_pkg::*;
#(
  parameter int AddrWidth = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic [AddrWidth-1:0] start_addr_i,
  input  logic [7:0]           len_i,
  input  logic [2:0]           size_i,
  input  burst_t               burst_i,
  input  logic                 advance_i,
  output logic [AddrWidth-1:0] addr_o,
  output logic [7:0]           cnt_o,
  output logic                 last_o
);

  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [7:0]           cnt_q, cnt_d;
  addr_t                next_addr_s;

  assign next_addr_s = next_beat_addr(addr_t'(addr_q), len_i, size_i, burst_i);

  // Next address/count: load on acceptance, step on a granted beat.
  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      addr_d = start_addr_i;
      cnt_d  = 8'd0;
    end else if (advance_i) begin
      addr_d = AddrWidth'(next_addr_s);
      cnt_d  = cnt_q + 8'd1;
    end else begin
      addr_d = addr_q;
      cnt_d  = cnt_q;
    end
  end

  // Address and counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q <= '0;
      cnt_q  <= 8'd0;
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign addr_o = addr_q;
  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == len_i);

endmodule

// File: rtl/axi_mem_burst_sched.sv
// Shares one single-ported memory between AXI read and write bursts:
// round-robin AX arbitration, per-beat memory requests, W pacing and B response.
module axi_mem_burst_sched
  import axi_mem_sched_pkg::*;
#(
  parameter int AddrWidth = 64,
  parameter int IdWidth   = 6,
  parameter int DataWidth = 128
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  axi_mem_burst_sched_if.slave bus
);

  localparam logic [2:0] MaxSize = 3'($clog2(DataWidth / 8));

  state_e               state_q, state_d;
  logic                 prefer_rd_q, prefer_rd_d;
  logic [7:0]           len_q, len_d;
  logic [2:0]           size_q, size_d;
  burst_t               burst_q, burst_d;
  logic [IdWidth-1:0]   id_q, id_d;
  logic                 err_q, err_d;

  logic                 grant_rd_s, grant_wr_s, load_s, advance_s;
  logic                 aw_ready_s, ar_ready_s, w_ready_s;
  logic                 mem_req_s, mem_we_s, b_valid_s;
  logic [AddrWidth-1:0] start_addr_s, beat_addr_s;
  logic [7:0]           beat_cnt_s;
  logic                 beat_last_s;

  // Readies are masked by reset so they fall together with the async reset.
  assign grant_rd_s = bus.ar_valid_i & ~rst_i & (~bus.aw_valid_i | prefer_rd_q);
  assign grant_wr_s = bus.aw_valid_i & ~rst_i & (~bus.ar_valid_i | ~prefer_rd_q);

  // Next-state, burst latching and handshake outputs.
  always_comb begin
    state_d      = state_q;
    prefer_rd_d  = prefer_rd_q;
    len_d        = len_q;
    size_d       = size_q;
    burst_d      = burst_q;
    id_d         = id_q;
    err_d        = err_q;
    load_s       = 1'b0;
    advance_s    = 1'b0;
    start_addr_s = bus.ar_addr_i;
    aw_ready_s   = 1'b0;
    ar_ready_s   = 1'b0;
    w_ready_s    = 1'b0;
    mem_req_s    = 1'b0;
    mem_we_s     = 1'b0;
    b_valid_s    = 1'b0;
    case (state_q)
      StIdle: begin
        ar_ready_s = grant_rd_s;
        aw_ready_s = grant_wr_s;
        if (bus.ar_valid_i && bus.aw_valid_i) begin
          prefer_rd_d = ~prefer_rd_q;
        end else begin
          prefer_rd_d = prefer_rd_q;
        end
        if (grant_rd_s) begin
          load_s       = 1'b1;
          start_addr_s = bus.ar_addr_i;
          len_d        = bus.ar_len_i;
          size_d       = bus.ar_size_i;
          burst_d      = eff_burst(bus.ar_burst_i, bus.ar_len_i);
          id_d         = bus.ar_id_i;
          err_d        = burst_err(bus.ar_burst_i, bus.ar_len_i, bus.ar_size_i, MaxSize);
          state_d      = StRead;
        end else if (grant_wr_s) begin
          load_s       = 1'b1;
          start_addr_s = bus.aw_addr_i;
          len_d        = bus.aw_len_i;
          size_d       = bus.aw_size_i;
          burst_d      = eff_burst(bus.aw_burst_i, bus.aw_len_i);
          id_d         = bus.aw_id_i;
          err_d        = burst_err(bus.aw_burst_i, bus.aw_len_i, bus.aw_size_i, MaxSize);
          state_d      = StWrite;
        end else begin
          state_d = StIdle;
        end
      end
      StRead: begin
        mem_req_s = 1'b1;
        advance_s = bus.mem_gnt_i;
        if (bus.mem_gnt_i && beat_last_s) begin
          state_d = StIdle;
        end else begin
          state_d = StRead;
        end
      end
      StWrite: begin
        mem_req_s = bus.w_valid_i;
        mem_we_s  = 1'b1;
        w_ready_s = bus.mem_gnt_i;
        advance_s = bus.w_valid_i & bus.mem_gnt_i;
        // The counter decides burst length; a misplaced w_last only flags an error.
        if (advance_s) begin
          if (bus.w_last_i != (beat_cnt_s == len_q)) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          if (beat_last_s) begin
            state_d = StWriteResp;
          end else begin
            state_d = StWrite;
          end
        end else begin
          state_d = StWrite;
        end
      end
      StWriteResp: begin
        b_valid_s = 1'b1;
        if (bus.b_ready_i) begin
          state_d = StIdle;
        end else begin
          state_d = StWriteResp;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, arbitration pointer and latched burst attributes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      prefer_rd_q <= 1'b1;
      len_q       <= 8'd0;
      size_q      <= 3'd0;
      burst_q     <= BurstFixed;
      id_q        <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      prefer_rd_q <= prefer_rd_d;
      len_q       <= len_d;
      size_q      <= size_d;
      burst_q     <= burst_d;
      id_q        <= id_d;
      err_q       <= err_d;
    end
  end

  axi_burst_addr_gen #(
    .AddrWidth(AddrWidth)
  ) u_addr_gen (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (load_s),
    .start_addr_i(start_addr_s),
    .len_i       (len_q),
    .size_i      (size_q),
    .burst_i     (burst_q),
    .advance_i   (advance_s),
    .addr_o      (beat_addr_s),
    .cnt_o       (beat_cnt_s),
    .last_o      (beat_last_s)
  );

  assign bus.aw_ready_o = aw_ready_s;
  assign bus.ar_ready_o = ar_ready_s;
  assign bus.w_ready_o  = w_ready_s;
  assign bus.mem_req_o  = mem_req_s;
  assign bus.mem_we_o   = mem_we_s;
  assign bus.mem_addr_o = beat_addr_s;
  assign bus.mem_id_o   = id_q;
  assign bus.mem_last_o = beat_last_s & ((state_q == StRead) | (state_q == StWrite));
  assign bus.mem_err_o  = err_q;
  assign bus.b_valid_o  = b_valid_s;
  assign bus.b_id_o     = id_q;
  assign bus.b_resp_o   = (b_valid_s && err_q) ? RespSlverr : RespOkay;

endmodule
